// File: rtl/piso_pkg.sv
// piso_pkg: shared types and helpers for the parallel-in serial-out transmitter.
//   state_e : transmitter state (IDLE, SHIFT)
//   cnt_w() : width of the bits-remaining counter for a given word width
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counter holds 0..WIDTH-1, so clog2(WIDTH) bits suffice (WIDTH >= 2).
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage : piso_pkg

// File: rtl/piso_tx_if.sv
// piso_tx_if: load handshake and serial output bundle of piso_tx.
//   din         : parallel word to transmit
//   load_valid  : din is valid this cycle
//   load_ready  : transmitter accepts din at the next rising edge
//   sout        : serial data bit
//   sout_valid  : sout carries a valid data bit
//   frame_start : first bit of a word is on sout
//   frame_done  : last bit of a word is on sout
//   busy        : transmitter is shifting
// master = word source / serial sink, slave = transmitter.
interface piso_tx_if #(
    parameter int unsigned WIDTH = 4
);

    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_done;
    logic             busy;

    modport master (
        output din,
        output load_valid,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  frame_start,
        input  frame_done,
        input  busy
    );

    modport slave (
        input  din,
        input  load_valid,
        output load_ready,
        output sout,
        output sout_valid,
        output frame_start,
        output frame_done,
        output busy
    );

endinterface : piso_tx_if

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one
// bit per clock, qualified by sout_valid with frame_start/frame_done markers.
// A new word may be accepted during the last bit of the current one, giving
// gapless back-to-back frames.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : piso_tx_if slave modport (load handshake + serial outputs)
// Parameters:
//   WIDTH     : word width in bits (>= 2)
//   MSB_FIRST : 1 = din[WIDTH-1] first, 0 = din[0] first
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    piso_tx_if.slave   bus
);

    localparam int unsigned      CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic ready;
    logic accept;
    logic sout_w;
    logic sout_valid_w;
    logic frame_start_w;
    logic frame_done_w;
    logic busy_w;

    // State, shift register and bits-remaining counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, handshake and output decode.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        sout_w        = 1'b0;
        sout_valid_w  = 1'b0;
        frame_start_w = 1'b0;
        frame_done_w  = 1'b0;
        busy_w        = 1'b0;

        // Ready while idle, or on the last bit so the next word follows with no gap.
        ready  = (state_q == IDLE) || (cnt_q == '0);
        accept = bus.load_valid && ready;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shreg_d = bus.din;
                    cnt_d   = CNT_LAST;
                end
            end
            SHIFT: begin
                sout_w        = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                sout_valid_w  = 1'b1;
                busy_w        = 1'b1;
                frame_start_w = (cnt_q == CNT_LAST);
                frame_done_w  = (cnt_q == '0);

                if (cnt_q != '0) begin
                    // Move the next bit to the output end, zero-filling behind it.
                    shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg_q[WIDTH-1:1]};
                    cnt_d   = cnt_q - CNT_W'(1);
                end else if (accept) begin
                    shreg_d = bus.din;
                    cnt_d   = CNT_LAST;
                end else begin
                    state_d = IDLE;
                    shreg_d = '0;
                end
            end
        endcase
    end

    assign bus.load_ready  = ready;
    assign bus.sout        = sout_w;
    assign bus.sout_valid  = sout_valid_w;
    assign bus.frame_start = frame_start_w;
    assign bus.frame_done  = frame_done_w;
    assign bus.busy        = busy_w;

endmodule : piso_tx

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter: the serializing end of the team's shift-register family. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock with a frame-valid qualifier. Supports gapless back-to-back words. Feeds a matching SIPO receiver or an off-block serial pin.

Parameters:
WIDTH, 4, data word width in bits (>= 2)
MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
din  input  WIDTH  parallel word to transmit
load_valid  input  1  din is valid this cycle
load_ready  output  1  block accepts din at the next rising edge
sout  output  1  serial data bit
sout_valid  output  1  sout carries a valid data bit this cycle
frame_start  output  1  high during the first bit of each word
frame_done  output  1  high during the last bit of each word
busy  output  1  high whenever state is SHIFT

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst.
- Reset (rst=0): state IDLE, shift register 0, bit counter 0. Outputs: sout=0, sout_valid=0, frame_start=0, frame_done=0, busy=0, load_ready=1.
- States:
  - IDLE: nothing is being transmitted.
  - SHIFT: a word is being transmitted. Counter cnt holds the number of bits remaining after the current one.
- Accept: a word is accepted at a rising edge when load_valid=1 and load_ready=1.
- load_ready is combinational: 1 in IDLE, 1 in SHIFT when cnt==0 (last bit), 0 otherwise.
- On accept: shreg<=din, cnt<=WIDTH-1, state<=SHIFT.
- Latency: word accepted at edge N puts its first bit on sout from edge N to N+1. The last bit is on sout from edge N+WIDTH-1 to N+WIDTH.
- In SHIFT:
  - sout = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - sout_valid=1.
  - frame_start=1 when cnt==WIDTH-1.
  - frame_done=1 when cnt==0.
- Each edge in SHIFT with cnt!=0: shreg shifts toward the output end, zero-filled; cnt decrements.
- Edge in SHIFT with cnt==0:
  - load_valid=1: accept the new word and stay in SHIFT. No idle bit between words; frame_done and the next frame_start occur on adjacent cycles.
  - load_valid=0: state<=IDLE, shreg<=0.
- In IDLE: sout=0, sout_valid=0, frame_start=0, frame_done=0.
- din is sampled only on the accept edge. Changes to din at other times have no effect on the word in flight.
- load_valid held high while load_ready=0: no accept, no state change, word in flight unaffected.
- Reset asserted mid-frame: the word is abandoned immediately (asynchronous). After release the block is IDLE and no partial word resumes.
- cnt width is CNT_W = $clog2(WIDTH). No arithmetic wraps because cnt never decrements below 0.

Decomposition:
- Shared package piso_pkg:
  - state enum {IDLE, SHIFT}.
  - function computing CNT_W from WIDTH.
- Single module; no sub-module needed. The shift register, counter and FSM are tightly coupled.

Test Plan:
- WIDTH=4, MSB_FIRST=1, din=1110 accepted at edge N -> sout=1,1,1,0 on cycles N..N+3. sout_valid=1 for those 4 cycles, frame_start at N, frame_done at N+3, then IDLE with sout_valid=0.
- Back-to-back: 1110 accepted, load_valid held with din=1010 at the last bit -> 8 contiguous valid bits 1,1,1,0,1,0,1,0. load_ready=1 only on bits 4 and 8; no gap cycle.
- load_valid=1 with din=0101 during bit 2 of 1110 -> not accepted (load_ready=0). Transmission stays 1,1,1,0.
- MSB_FIRST=0, din=0011 -> sout=1,1,0,0.
- rst driven low at bit 2 of 1110 -> all outputs 0 immediately. After release: load_ready=1, sout_valid=0 until the next accept.
- Reset idle check after release -> busy=0, sout=0, no spurious frame_start or frame_done with load_valid=0 for 10 cycles.
